// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - multi-cycle slice-serial 32-bit adder/subtractor with carry, overflow and zero flags
module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = WIDTH / SLICE;
    localparam int NW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [NW-1:0] LAST = NW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [NW-1:0]    n;
    logic             a_msb;
    logic             b_msb;

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;

    // Low slice of the operands plus the running carry; the accumulator fills from the top
    // so that after the last slice the LSB slice has been shifted down to bit 0.
    always_comb begin
        slice_sum = {1'b0, sa[SLICE-1:0]} + {1'b0, sb[SLICE-1:0]} + {{SLICE{1'b0}}, c};
        acc_next  = {slice_sum[SLICE-1:0], acc[WIDTH-1:SLICE]};
    end

    // Control FSM and datapath; result/flags only update on the final slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            c      <= 1'b0;
            n      <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        c     <= sub;
                        n     <= '0;
                        acc   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> SLICE;
                    sb  <= sb >> SLICE;
                    c   <= slice_sum[SLICE];
                    acc <= acc_next;
                    n   <= n + NW'(1);
                    if (n == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                        cout   <= slice_sum[SLICE];
                        ovf    <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
                        zero   <= (acc_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
